// File: rtl/outpkt_tx_pkg.sv
// Shared definitions for the output packet transmitter.
package outpkt_tx_pkg;

    localparam int unsigned HDR_WORDS           = 3;
    localparam int unsigned CSUM_W              = 16;
    localparam int unsigned HDR_BITS            = HDR_WORDS * CSUM_W;
    localparam int unsigned DEFAULT_PKT_VERSION = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_HDR_CSUM,
        ST_DATA,
        ST_DATA_CSUM
    } state_e;

endpackage

// File: rtl/outpkt_tx_csum.sv
// 16-bit wrapping ones'-complement-style checksum accumulator (carries dropped).
module pkt_csum16
    import outpkt_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [CSUM_W-1:0] data_i,
    output logic [CSUM_W-1:0] csum_o
);

    logic [CSUM_W-1:0] sum_q, sum_d;

    // Next sum: clear wins over add so a new packet always starts from zero.
    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign csum_o = ~sum_q;

endmodule

// File: rtl/outpkt_tx.sv
// Frames a packet request into header, header checksum, payload and payload
// checksum words and writes them to the output FIFO.
module outpkt_tx
    import outpkt_tx_pkg::*;
#(
    parameter int unsigned PKT_VERSION = DEFAULT_PKT_VERSION,
    parameter logic [15:0] PKT_MAX_LEN = 16'd4096
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pkt_type,
    input  logic [15:0] pkt_id,
    input  logic [15:0] pkt_len,
    output logic        ready,
    input  logic [15:0] src_dout,
    input  logic        src_empty,
    output logic        src_rd_en,
    output logic [15:0] dout,
    output logic        wr_en,
    input  logic        full,
    output logic        err_len,
    output logic        pkt_done
);

    state_e              state_q, state_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_len_q, err_len_d;
    logic                done_q, done_d;
    logic                csum_clr, csum_add;
    logic [CSUM_W-1:0]   csum;

    // Single checksum engine, cleared between header and payload.
    pkt_csum16 u_csum (
        .clk     (CLK),
        .rst     (rst),
        .clear_i (csum_clr),
        .add_i   (csum_add),
        .data_i  (dout),
        .csum_o  (csum)
    );

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hdr_q     <= '0;
            cnt_q     <= '0;
            err_len_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
            done_q    <= done_d;
        end
    end

    // Next-state and word emission; strobes follow full/src_empty in the same cycle.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        err_len_d = err_len_q;
        done_d    = 1'b0;
        csum_clr  = 1'b0;
        csum_add  = 1'b0;
        wr_en     = 1'b0;
        src_rd_en = 1'b0;
        dout      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pkt_len > PKT_MAX_LEN) begin
                        err_len_d = 1'b1;
                    end else begin
                        hdr_d    = {pkt_type, 8'(PKT_VERSION), pkt_id, pkt_len};
                        cnt_d    = pkt_len;
                        csum_clr = 1'b1;
                        state_d  = ST_HDR0;
                    end
                end
            end
            ST_HDR0: begin
                dout     = hdr_q[HDR_BITS-1 -: CSUM_W];
                wr_en    = !full;
                csum_add = wr_en;
                if (wr_en) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                dout     = hdr_q[HDR_BITS-CSUM_W-1 -: CSUM_W];
                wr_en    = !full;
                csum_add = wr_en;
                if (wr_en) state_d = ST_HDR2;
            end
            ST_HDR2: begin
                dout     = hdr_q[CSUM_W-1:0];
                wr_en    = !full;
                csum_add = wr_en;
                if (wr_en) state_d = ST_HDR_CSUM;
            end
            ST_HDR_CSUM: begin
                dout  = csum;
                wr_en = !full;
                if (wr_en) begin
                    csum_clr = 1'b1;
                    if (cnt_q == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                dout      = src_dout;
                wr_en     = !full && !src_empty;
                src_rd_en = wr_en;
                csum_add  = wr_en;
                if (wr_en) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = ST_DATA_CSUM;
                end
            end
            ST_DATA_CSUM: begin
                dout  = csum;
                wr_en = !full;
                if (wr_en) begin
                    csum_clr = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready    = (state_q == ST_IDLE);
    assign err_len  = err_len_q;
    assign pkt_done = done_q;

endmodule

// File: tb/tb_outpkt_tx.sv
// Directed scoreboard bench for outpkt_tx.
module tb_outpkt_tx;

    localparam logic [15:0] MAX_LEN = 16'd4096;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pkt_type = '0;
    logic [15:0] pkt_id = '0;
    logic [15:0] pkt_len = '0;
    logic        ready;
    logic [15:0] src_dout = '0;
    logic        src_empty = 1'b1;
    logic        src_rd_en;
    logic [15:0] dout;
    logic        wr_en;
    logic        full = 1'b0;
    logic        err_len;
    logic        pkt_done;

    always #5 CLK = ~CLK;

    outpkt_tx #(
        .PKT_VERSION (2),
        .PKT_MAX_LEN (MAX_LEN)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .start     (start),
        .pkt_type  (pkt_type),
        .pkt_id    (pkt_id),
        .pkt_len   (pkt_len),
        .ready     (ready),
        .src_dout  (src_dout),
        .src_empty (src_empty),
        .src_rd_en (src_rd_en),
        .dout      (dout),
        .wr_en     (wr_en),
        .full      (full),
        .err_len   (err_len),
        .pkt_done  (pkt_done)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] src_q[$];
    logic [15:0] pl[$];
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int          cyc = 0, first_wr = 0, last_wr = 0, done_cyc = 0, acc_cyc = 0;
    int          hold_cnt = 0, pops = 0, hold_target = -1;
    logic        full_toggle = 1'b0;
    logic        ready_at_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic src_refresh();
        src_empty = (hold_cnt > 0) || (src_q.size() == 0);
        src_dout  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    endtask

    // One clock: monitor/scoreboard at negedge, then source FIFO and full update after posedge.
    task automatic cycle();
        logic rd;
        logic [15:0] e;
        @(negedge CLK);
        rd = src_rd_en;
        if (!rst) begin
            check("no_wr_while_full", 32'(wr_en && full), 32'd0);
            check("no_rd_while_empty", 32'(src_rd_en && src_empty), 32'd0);
            if (wr_en) begin
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word", 32'(dout), 32'(e));
                end
                wr_cnt++;
                if (wr_cnt == 1) first_wr = cyc;
                last_wr = cyc;
            end
            if (src_rd_en) rd_cnt++;
            if (pkt_done) begin
                done_cnt++;
                done_cyc      = cyc;
                ready_at_done = ready;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rd && src_q.size() > 0) begin
            void'(src_q.pop_front());
            pops++;
            if (pops == hold_target) hold_cnt = 3;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
        end
        full = full_toggle ? ~full : 1'b0;
        src_refresh();
    endtask

    task automatic send(input logic [7:0] t, input logic [15:0] id, input logic [15:0] len);
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; ready_at_done = 1'b0;
        start = 1'b1; pkt_type = t; pkt_id = id; pkt_len = len;
        cycle();
        start = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
        cycle();
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_ready_at_done"}, 32'(ready_at_done), 32'd1);
    endtask

    // Reference framing built from the payload list pl.
    task automatic load_pkt(input logic [7:0] t, input logic [15:0] id);
        logic [15:0] s;
        logic [15:0] h0;
        logic [15:0] n;
        s  = 16'h0000;
        h0 = {t, 8'h02};
        n  = 16'(pl.size());
        exp_q.push_back(h0);
        exp_q.push_back(id);
        exp_q.push_back(n);
        exp_q.push_back(~(h0 + id + n));
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            src_q.push_back(pl[i]);
            s = s + pl[i];
        end
        if (pl.size() > 0) exp_q.push_back(~s);
        src_refresh();
    endtask

    task automatic load_ref_a();
        src_q.push_back(16'h0001);
        src_q.push_back(16'h0002);
        exp_q.push_back(16'h8102); exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0002); exp_q.push_back(16'h6CC7);
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFFFC);
        src_refresh();
    endtask

    initial begin
        int n;
        src_refresh();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_src_rd_en", 32'(src_rd_en), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        rst = 1'b0;
        cycle();

        // Basic packet, no back-pressure.
        load_ref_a();
        send(8'h81, 16'h1234, 16'd2);
        wait_done("A", 100);
        check("A_wr_cnt", 32'(wr_cnt), 32'd7);
        check("A_contiguous", 32'(last_wr - first_wr + 1), 32'd7);
        check("A_first_latency", 32'(first_wr), 32'(acc_cyc));
        check("A_done_timing", 32'(done_cyc), 32'(last_wr + 1));
        check("A_rd_cnt", 32'(rd_cnt), 32'd2);

        // Zero-length packet: header only.
        exp_q.push_back(16'h0102); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'hFEFD);
        send(8'h01, 16'h0000, 16'd0);
        wait_done("B", 100);
        check("B_wr_cnt", 32'(wr_cnt), 32'd4);
        check("B_rd_cnt", 32'(rd_cnt), 32'd0);

        // Same as A with full toggling and a 3-cycle source underrun mid-payload.
        full_toggle = 1'b1;
        hold_target = pops + 1;
        load_ref_a();
        send(8'h81, 16'h1234, 16'd2);
        wait_done("C", 200);
        check("C_wr_cnt", 32'(wr_cnt), 32'd7);
        check("C_rd_cnt", 32'(rd_cnt), 32'd2);
        full_toggle = 1'b0;
        cycle();

        // Carry discarded in payload checksum.
        src_q.push_back(16'hFFFF);
        src_q.push_back(16'h0002);
        exp_q.push_back(16'h1002); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0002); exp_q.push_back(16'hEFFB);
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFFFE);
        src_refresh();
        send(8'h10, 16'h0000, 16'd2);
        wait_done("E", 100);

        // Maximum legal length is accepted.
        pl.delete();
        for (int i = 0; i < int'(MAX_LEN); i++) pl.push_back(16'(i * 7 + 3));
        load_pkt(8'h5A, 16'hC0DE);
        send(8'h5A, 16'hC0DE, MAX_LEN);
        wait_done("MAX", 5000);
        check("MAX_wr_cnt", 32'(wr_cnt), 32'(int'(MAX_LEN) + 5));
        check("MAX_err_len", 32'(err_len), 32'd0);

        // Over-length request rejected, sticky error, then normal packet.
        send(8'h33, 16'h0001, MAX_LEN + 16'd1);
        repeat (4) cycle();
        check("D_no_writes", 32'(wr_cnt), 32'd0);
        check("D_err_len", 32'(err_len), 32'd1);
        check("D_ready", 32'(ready), 32'd1);
        pl.delete();
        pl.push_back(16'h1111); pl.push_back(16'h2222); pl.push_back(16'h3333);
        load_pkt(8'h22, 16'hBEEF);
        send(8'h22, 16'hBEEF, 16'd3);
        wait_done("D2", 100);
        check("D2_err_len_sticky", 32'(err_len), 32'd1);

        // Reset in the middle of the payload.
        pl.delete();
        pl.push_back(16'h000A); pl.push_back(16'h000B);
        pl.push_back(16'h000C); pl.push_back(16'h000D);
        load_pkt(8'h44, 16'h5555);
        send(8'h44, 16'h5555, 16'd4);
        n = 0;
        while (rd_cnt < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("F_reached_data", 32'(rd_cnt), 32'd2);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        check("F_ready", 32'(ready), 32'd1);
        check("F_wr_en", 32'(wr_en), 32'd0);
        check("F_src_rd_en", 32'(src_rd_en), 32'd0);
        check("F_err_len_cleared", 32'(err_len), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        src_q.delete();
        hold_cnt = 0;
        src_refresh();
        cycle();
        load_ref_a();
        send(8'h81, 16'h1234, 16'd2);
        wait_done("F2", 100);
        check("F2_wr_cnt", 32'(wr_cnt), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
